// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle MIPS sequencer
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps aluop and funct to the ALU control code
module mc_alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   // Fixed add/sub for address and branch math, funct lookup for R-type
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alucontrol = ALU_ADD;
               FUNCT_SUB: alucontrol = ALU_SUB;
               FUNCT_AND: alucontrol = ALU_AND;
               FUNCT_OR:  alucontrol = ALU_OR;
               FUNCT_SLT: alucontrol = ALU_SLT;
               default:   alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS Moore sequencer; MC_CONTROLLER_BNE_EN adds bne
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [5:0] op_i6,
   input  logic [5:0] funct_i6,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       iord_o,
   output logic       irwrite_o,
   output logic       pcwrite_o,
   output logic       memwrite_o,
   output logic       regwrite_o,
   output logic       regdst_o,
   output logic       memtoreg_o,
   output logic       alusrca_o,
   output logic [1:0] alusrcb_o2,
   output logic [1:0] pcsrc_o2,
   output logic [2:0] alucontrol_o3,
   output logic       illegal_o,
   output logic [3:0] state_o4
);

   state_t     state;
   state_t     decode_next;
   logic       decode_illegal;
   logic       branch_take;
   logic [1:0] aluop;
   logic       irwrite_raw;
   logic       pcwrite_raw;
   logic       memwrite_raw;
   logic       regwrite_raw;

   // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH
   always_comb begin
      decode_next    = S_FETCH;
      decode_illegal = 1'b0;
      case (op_i6)
         OP_LW, OP_SW: decode_next = S_MEMADR;
         OP_RTYPE:     decode_next = S_EXECUTE;
         OP_BEQ:       decode_next = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
         OP_BNE:       decode_next = S_BRANCH;
`endif
         OP_ADDI:      decode_next = S_ADDIEXEC;
         OP_J:         decode_next = S_JUMP;
         default:      decode_illegal = 1'b1;
      endcase
   end

   // Branch condition: bne inverts the zero flag when enabled
   always_comb begin
`ifdef MC_CONTROLLER_BNE_EN
      branch_take = (op_i6 == OP_BNE) ? ~zero_i : zero_i;
`else
      branch_take = zero_i;
`endif
   end

   // State register with next-state selection; memory states wait for ready
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:    state <= mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:   state <= decode_next;
            S_MEMADR:   state <= (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state <= mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWR:    state <= mem_ready_i ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_ADDIEXEC: state <= S_ADDIWB;
            S_ADDIWB:   state <= S_FETCH;
            S_JUMP:     state <= S_FETCH;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Per-state datapath control; anything not named for a state stays 0
   always_comb begin
      iord_o       = 1'b0;
      irwrite_raw  = 1'b0;
      pcwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      regdst_o     = 1'b0;
      memtoreg_o   = 1'b0;
      alusrca_o    = 1'b0;
      alusrcb_o2   = SRCB_B;
      pcsrc_o2     = PCSRC_ALURESULT;
      aluop        = ALUOP_ADD;
      illegal_o    = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb_o2  = SRCB_FOUR;
            irwrite_raw = mem_ready_i;
            pcwrite_raw = mem_ready_i;
         end
         S_DECODE: begin
            alusrcb_o2 = SRCB_IMMSH2;
            illegal_o  = decode_illegal;
         end
         S_MEMADR: begin
            alusrca_o  = 1'b1;
            alusrcb_o2 = SRCB_IMM;
         end
         S_MEMRD: iord_o = 1'b1;
         S_MEMWB: begin
            memtoreg_o   = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_MEMWR: begin
            iord_o       = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_EXECUTE: begin
            alusrca_o = 1'b1;
            aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst_o     = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_BRANCH: begin
            alusrca_o   = 1'b1;
            aluop       = ALUOP_SUB;
            pcsrc_o2    = PCSRC_ALUOUT;
            pcwrite_raw = branch_take;
         end
         S_ADDIEXEC: begin
            alusrca_o  = 1'b1;
            alusrcb_o2 = SRCB_IMM;
         end
         S_ADDIWB: regwrite_raw = 1'b1;
         S_JUMP: begin
            pcsrc_o2    = PCSRC_JUMP;
            pcwrite_raw = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset holds every write enable low even though FETCH would follow ready
   assign irwrite_o  = irwrite_raw  & reset_ni;
   assign pcwrite_o  = pcwrite_raw  & reset_ni;
   assign memwrite_o = memwrite_raw & reset_ni;
   assign regwrite_o = regwrite_raw & reset_ni;
   assign state_o4   = state;

   mc_alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct      (funct_i6),
      .alucontrol (alucontrol_o3)
   );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       ready;
   logic       iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluctl;
   logic       illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .op_i6         (op),
      .funct_i6      (funct),
      .zero_i        (zero),
      .mem_ready_i   (ready),
      .iord_o        (iord),
      .irwrite_o     (irwrite),
      .pcwrite_o     (pcwrite),
      .memwrite_o    (memwrite),
      .regwrite_o    (regwrite),
      .regdst_o      (regdst),
      .memtoreg_o    (memtoreg),
      .alusrca_o     (alusrca),
      .alusrcb_o2    (alusrcb),
      .pcsrc_o2      (pcsrc),
      .alucontrol_o3 (aluctl),
      .illegal_o     (illegal),
      .state_o4      (state)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0; ready = 1'b1;
      #2;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
      checks++;
      if ({irwrite, pcwrite, memwrite, regwrite} !== 4'b0000) begin
         errors++; $display("FAIL reset_enables got %b exp 0000", {irwrite, pcwrite, memwrite, regwrite});
      end
      checks++;
      if ({alusrca, alusrcb, pcsrc, aluctl, iord, illegal} !== {1'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_fetch_ctl got %b", {alusrca, alusrcb, pcsrc, aluctl, iord, illegal});
      end
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic       exp_wb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      op = 6'b100011; ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (state !== exp_st[c]) begin errors++; $display("FAIL lw_state c%0d got %0d exp %0d", c, state, exp_st[c]); end
         checks++;
         if (regwrite !== exp_wb[c] || memtoreg !== exp_wb[c]) begin
            errors++; $display("FAIL lw_wb c%0d got rw=%b m2r=%b exp %b", c, regwrite, memtoreg, exp_wb[c]);
         end
         next_cycle();
      end
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL lw_end got %0d exp 0", state); end
   endtask

   task automatic test_sw_stall();
      logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
      logic       rdy    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       exp_mw [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      op = 6'b101011;
      for (int c = 0; c < 6; c++) begin
         ready = rdy[c];
         #1;
         checks++;
         if (state !== exp_st[c]) begin errors++; $display("FAIL sw_state c%0d got %0d exp %0d", c, state, exp_st[c]); end
         checks++;
         if (memwrite !== exp_mw[c] || iord !== exp_mw[c]) begin
            errors++; $display("FAIL sw_memwrite c%0d got mw=%b iord=%b exp %b", c, memwrite, iord, exp_mw[c]);
         end
         checks++;
         if ((c >= 3) && ({pcwrite, irwrite, regwrite} !== 3'b000)) begin
            errors++; $display("FAIL sw_stall_en c%0d got %b exp 000", c, {pcwrite, irwrite, regwrite});
         end
         next_cycle();
      end
      ready = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL sw_end got %0d exp 0", state); end
   endtask

   task automatic test_fetch_stall();
      op = 6'b000010; ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (state !== 4'd0 || irwrite !== 1'b0 || pcwrite !== 1'b0) begin
            errors++; $display("FAIL fetch_stall c%0d got st=%0d ir=%b pc=%b exp 0 0 0", c, state, irwrite, pcwrite);
         end
         next_cycle();
      end
      ready = 1'b1;
      // j: FETCH, DECODE, JUMP
      next_cycle();
      next_cycle();
      checks++;
      if (state !== 4'd11 || pcwrite !== 1'b1 || pcsrc !== 2'b10) begin
         errors++; $display("FAIL jump got st=%0d pc=%b src=%b exp 11 1 10", state, pcwrite, pcsrc);
      end
      next_cycle();
   endtask

   task automatic test_rtype();
      logic [5:0] f   [4] = '{6'b101010, 6'b100010, 6'b100101, 6'b111111};
      logic [2:0] exp [4] = '{3'b111, 3'b110, 3'b001, 3'b010};
      op = 6'b000000; ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         funct = f[i];
         next_cycle();
         next_cycle();
         checks++;
         if (state !== 4'd6 || aluctl !== exp[i] || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
            errors++; $display("FAIL rtype_exec f=%b got st=%0d alu=%b exp 6 %b", f[i], state, aluctl, exp[i]);
         end
         next_cycle();
         checks++;
         if (state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1 || memtoreg !== 1'b0) begin
            errors++; $display("FAIL rtype_wb got st=%0d rd=%b rw=%b m2r=%b exp 7 1 1 0", state, regdst, regwrite, memtoreg);
         end
         next_cycle();
      end
   endtask

   task automatic test_branch();
      op = 6'b000100; ready = 1'b1;
      for (int z = 0; z < 2; z++) begin
         zero = z[0];
         next_cycle();
         next_cycle();
         checks++;
         if (state !== 4'd8 || pcwrite !== z[0] || pcsrc !== 2'b01 || aluctl !== 3'b110) begin
            errors++; $display("FAIL beq z=%0d got st=%0d pc=%b src=%b alu=%b exp 8 %0d 01 110", z, state, pcwrite, pcsrc, aluctl, z);
         end
         next_cycle();
      end
      op = 6'b000101; zero = 1'b0;
      next_cycle();
`ifdef MC_CONTROLLER_BNE_EN
      next_cycle();
      checks++;
      if (state !== 4'd8 || pcwrite !== 1'b1) begin
         errors++; $display("FAIL bne got st=%0d pc=%b exp 8 1", state, pcwrite);
      end
      next_cycle();
`else
      checks++;
      if (state !== 4'd1 || illegal !== 1'b1) begin
         errors++; $display("FAIL bne_illegal got st=%0d ill=%b exp 1 1", state, illegal);
      end
      next_cycle();
`endif
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL bne_end got %0d exp 0", state); end
      zero = 1'b0;
   endtask

   task automatic test_addi();
      op = 6'b001000; ready = 1'b1;
      next_cycle();
      next_cycle();
      checks++;
      if (state !== 4'd9 || alusrcb !== 2'b10 || aluctl !== 3'b010) begin
         errors++; $display("FAIL addi_exec got st=%0d srcb=%b alu=%b exp 9 10 010", state, alusrcb, aluctl);
      end
      next_cycle();
      checks++;
      if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
         errors++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b m2r=%b exp 10 1 0 0", state, regwrite, regdst, memtoreg);
      end
      next_cycle();
   endtask

   task automatic test_illegal();
      op = 6'b111111; ready = 1'b1;
      #1;
      checks++;
      if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_fetch got %b exp 0", illegal); end
      next_cycle();
      checks++;
      if (state !== 4'd1 || illegal !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
         errors++; $display("FAIL illegal_decode got st=%0d ill=%b rw=%b mw=%b exp 1 1 0 0", state, illegal, regwrite, memwrite);
      end
      next_cycle();
      checks++;
      if (state !== 4'd0 || illegal !== 1'b0) begin
         errors++; $display("FAIL illegal_next got st=%0d ill=%b exp 0 0", state, illegal);
      end
   endtask

   task automatic test_reset_mid_memwr();
      op = 6'b101011; ready = 1'b1;
      next_cycle();
      next_cycle();
      ready = 1'b0;
      next_cycle();
      checks++;
      if (state !== 4'd5 || memwrite !== 1'b1) begin
         errors++; $display("FAIL rst_pre got st=%0d mw=%b exp 5 1", state, memwrite);
      end
      rst_n = 1'b0;
      ready = 1'b1;
      #1;
      checks++;
      if (memwrite !== 1'b0 || pcwrite !== 1'b0 || state !== 4'd0) begin
         errors++; $display("FAIL rst_mid got mw=%b pc=%b st=%0d exp 0 0 0", memwrite, pcwrite, state);
      end
      next_cycle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0 || pcwrite !== 1'b1 || irwrite !== 1'b1) begin
         errors++; $display("FAIL rst_release got st=%0d pc=%b ir=%b exp 0 1 1", state, pcwrite, irwrite);
      end
      op = 6'b000010;
      next_cycle();
      next_cycle();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_fetch_stall();
      test_rtype();
      test_branch();
      test_addi();
      test_illegal();
      test_reset_mid_memwr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencer for the MIPS datapath: a Moore FSM that decodes the instruction-register opcode and drives the multicycle datapath's muxes and write enables, one microstep per clock. It shares a single memory port between instruction fetch and data access (`iord_o`) and stalls on a memory-ready handshake. It sits beside the multicycle datapath at the same level as the single-cycle controller, and takes `op_i6`/`funct_i6` from the datapath's instruction register.

## Interface
No parameters.
- `clk_i` input 1: clock, rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `op_i6` input 6: opcode from the instruction register.
- `funct_i6` input 6: funct field from the instruction register.
- `zero_i` input 1: ALU zero flag.
- `mem_ready_i` input 1: memory has completed the current access this cycle.
- `iord_o` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `irwrite_o` output 1: load the instruction register.
- `pcwrite_o` output 1: PC enable, with the branch condition already folded in.
- `memwrite_o` output 1: data memory write request.
- `regwrite_o` output 1: register file write.
- `regdst_o` output 1: 1 = rd, 0 = rt.
- `memtoreg_o` output 1: 1 = Data register, 0 = ALUOut.
- `alusrca_o` output 1: 0 = PC, 1 = register A.
- `alusrcb_o2` output 2: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc_o2` output 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol_o3` output 3: ALU operation.
- `illegal_o` output 1: one-cycle pulse when an unsupported opcode is seen in DECODE.
- `state_o4` output 4: current state, for debug.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- **FETCH:** alusrca=0, alusrcb=01, pcsrc=00, ALU add.
  - irwrite and pcwrite are both equal to `mem_ready_i`.
  - Go to DECODE when `mem_ready_i` = 1; otherwise stay in FETCH.
- **DECODE:** alusrca=0, alusrcb=11, ALU add (branch target into ALUOut). Next state by opcode:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → EXECUTE
  - beq 000100 → BRANCH
  - addi 001000 → ADDIEXEC
  - j 000010 → JUMP
  - any other opcode → FETCH, with `illegal_o` = 1
- **MEMADR:** alusrca=1, alusrcb=10, ALU add. Next state is MEMRD for lw, MEMWR for sw.
- **MEMRD:** iord=1. Stay until `mem_ready_i`, then go to MEMWB.
- **MEMWB:** regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- **MEMWR:** iord=1 and memwrite=1, both held until `mem_ready_i`, then go to FETCH.
- **EXECUTE:** alusrca=1, alusrcb=00, ALU controlled by funct. Next state ALUWB.
- **ALUWB:** regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- **BRANCH:** alusrca=1, alusrcb=00, ALU sub, pcsrc=01, pcwrite=`zero_i`. Next state FETCH.
- **ADDIEXEC:** alusrca=1, alusrcb=10, ALU add. Next state ADDIWB.
- **ADDIWB:** regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- **JUMP:** pcsrc=10, pcwrite=1. Next state FETCH.
- **Defaults:** every output not listed for a state is 0.
- **ALU encoding:** add=010, sub=110, and=000, or=001, slt=111.
- **Funct decode:**
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - any other funct → 010 (no illegal flag).

## Timing
- **Reset:** asynchronous, active-low.
  - While `reset_ni` = 0, the state is FETCH and all enables (irwrite, pcwrite, memwrite, regwrite) are forced to 0.
  - All other outputs take their FETCH values.
  - `illegal_o` = 0.
- **Reset mid-instruction:** aborts the instruction with no write. Release resumes in FETCH.
- **Outputs:** Moore outputs decode combinationally from the state register. The exceptions are FETCH irwrite/pcwrite, which depend on `mem_ready_i`, and BRANCH pcwrite, which depends on `zero_i`.
- **Latency with `mem_ready_i` tied to 1:**
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi 4 cycles
  - beq 3 cycles
  - j 3 cycles
- **Stalls:** each cycle of `mem_ready_i` = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle. While stalled, no enables are asserted except memwrite in MEMWR.
- **Operand stability:** `op_i6` and `funct_i6` are sampled only in DECODE, MEMADR, EXECUTE and BRANCH. The IR is not written outside FETCH, so they are stable in those states.

## Configuration
- `MC_CONTROLLER_BNE_EN` defined: adds bne (opcode 000101).
  - DECODE routes bne to BRANCH.
  - In BRANCH, pcwrite = `zero_i` for beq and `~zero_i` for bne, selected by `op_i6`.
- Not defined: 000101 is illegal (`illegal_o` pulse, return to FETCH).

## Structure
- **Package `mc_pkg`:**
  - state enum, 4 bits, FETCH=0 … JUMP=11 in the listed order
  - opcode constants
  - funct constants
  - ALU control constants
  - alusrcb and pcsrc encodings
- **Sub-module `mc_alu_decoder`:** combinational; inputs are a 2-bit aluop (00 add, 01 sub, 10 funct) and funct; output is alucontrol.
- **`mc_controller`:** holds the state register, next-state logic and the output decode.

## Test plan
- Reset low mid-MEMWR, then release → memwrite=0 during reset; `state_o4`=0 and pcwrite=1 in the first cycle after release with ready=1.
- lw (op 100011), ready=1 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- sw with ready low for 2 cycles in MEMWR → memwrite held for 3 cycles, then FETCH; total 6 cycles.
- R-type funct 101010 → alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB.
- beq with zero_i=1 → pcwrite=1 and pcsrc=01 in BRANCH; with zero_i=0 → pcwrite=0.
  - With `MC_CONTROLLER_BNE_EN`: bne with zero_i=0 → pcwrite=1.
- Opcode 111111 → `illegal_o` pulses in DECODE, next state FETCH, no regwrite or memwrite.
